// File: rtl/fetch_stage.sv
// Instruction fetch stage: a single-outstanding memory requester feeding a 2-entry
// {pc, instruction} FIFO toward decode. Optional FETCH_COUNT_EN adds a transfer counter.
module fetch_stage #(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [15:0]       palavra,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_COUNT_EN
  output logic [15:0]       fetch_count,
`endif
  output logic [1:0]        dbg_state
);

  // Handshakes: memory accepts when mem_req && mem_ack (data valid same cycle);
  // decode accepts when inst_valid && !stall. Redirect cancels both in its cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              head_q, tail_q;
  logic [ADDR_W-1:0] pc_mem_q   [2];
  logic [15:0]       data_mem_q [2];

  logic       push, pop;
  logic [1:0] occ_pop, occ_next;

  assign inst_valid = (cnt_q != 2'd0);
  assign palavra    = data_mem_q[head_q];
  assign inst_pc    = pc_mem_q[head_q];
  assign mem_req    = (state_q == S_WAIT) || (state_q == S_DROP);
  assign mem_addr   = addr_q;
  assign dbg_state  = state_q;

  always_comb begin
    pop      = inst_valid & ~stall & ~redirect;
    push     = (state_q == S_WAIT) & mem_ack & ~redirect;
    occ_pop  = cnt_q - {1'b0, pop};
    occ_next = cnt_q + {1'b0, push} - {1'b0, pop};
    cnt_d    = redirect ? 2'd0 : occ_next;
    state_d  = state_q;
    addr_d   = addr_q;
    pc_d     = pc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          state_d = S_WAIT;
          addr_d  = redirect_pc;
          pc_d    = redirect_pc;
        end else if (occ_pop < 2'd2) begin
          state_d = S_WAIT;
          addr_d  = pc_q;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = redirect_pc;
          if (mem_ack) begin
            addr_d = redirect_pc;
          end else begin
            state_d = S_DROP;
          end
        end else if (mem_ack) begin
          addr_d  = addr_q + 1'b1;
          pc_d    = addr_q + 1'b1;
          state_d = (occ_next < 2'd2) ? S_WAIT : S_IDLE;
        end
      end
      S_DROP: begin
        // mem_addr stays on the abandoned request; pc_q carries the redirect target.
        if (redirect) pc_d = redirect_pc;
        if (mem_ack) begin
          state_d = S_WAIT;
          addr_d  = redirect ? redirect_pc : pc_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= RESET_PC;
      pc_q          <= RESET_PC;
      cnt_q         <= 2'd0;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      pc_mem_q[0]   <= '0;
      pc_mem_q[1]   <= '0;
      data_mem_q[0] <= '0;
      data_mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      if (redirect) begin
        head_q <= 1'b0;
        tail_q <= 1'b0;
      end else begin
        if (push) begin
          pc_mem_q[tail_q]   <= addr_q;
          data_mem_q[tail_q] <= mem_data;
          tail_q             <= ~tail_q;
        end
        if (pop) head_q <= ~head_q;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] fcnt_q;
  assign fetch_count = fcnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   fcnt_q <= 16'd0;
    else if (pop) fcnt_q <= fcnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns {8'hC3, addr}; outputs checked on negedges.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] palavra;
  logic        inst_valid;
  logic [7:0]  inst_pc;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_data = {8'hC3, mem_addr};

  fetch_stage #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .palavra(palavra), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef FETCH_COUNT_EN
    .fetch_count(fetch_count),
`endif
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_valid", inst_valid, 0);
    chk("rst_palavra", palavra, 16'h0000);
    chk("rst_pc", inst_pc, 8'h00);
    chk("rst_state", dbg_state, 2'd0);

    // Streaming: one instruction per cycle.
    rst_n = 1'b1; mem_ack = 1'b1;
    step();
    chk("s0_req", mem_req, 1);
    chk("s0_addr", mem_addr, 8'h00);
    chk("s0_valid", inst_valid, 0);
    step();
    chk("s1_addr", mem_addr, 8'h01);
    chk("s1_pc", inst_pc, 8'h00);
    chk("s1_palavra", palavra, 16'hC300);
    step();
    chk("s2_addr", mem_addr, 8'h02);
    chk("s2_pc", inst_pc, 8'h01);
    step();
    chk("s3_addr", mem_addr, 8'h03);
    chk("s3_pc", inst_pc, 8'h02);

    // Stall for 5 cycles: FIFO fills to 2 and requests stop.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stl_req", mem_req, 0);
      chk("stl_pc", inst_pc, 8'h02);
      chk("stl_palavra", palavra, 16'hC302);
      chk("stl_valid", inst_valid, 1);
    end
    chk("stl_state", dbg_state, 2'd0);
    stall = 1'b0;
    step();
    chk("drn0_pc", inst_pc, 8'h03);
    chk("drn0_palavra", palavra, 16'hC303);
    chk("drn0_req", mem_req, 1);
    chk("drn0_addr", mem_addr, 8'h04);
    step();
    chk("drn1_pc", inst_pc, 8'h04);
    chk("drn1_addr", mem_addr, 8'h05);

    // Redirect while the request to 05 is outstanding and unacked.
    mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 8'h40;
    step();
    redirect = 1'b0;
    chk("drp_valid", inst_valid, 0);
    chk("drp_req", mem_req, 1);
    chk("drp_addr", mem_addr, 8'h05);
    chk("drp_state", dbg_state, 2'd2);
    step();
    chk("drp1_valid", inst_valid, 0);
    step();
    chk("drp2_valid", inst_valid, 0);
    chk("drp2_addr", mem_addr, 8'h05);
    mem_ack = 1'b1;
    step();
    chk("drp3_valid", inst_valid, 0);
    chk("drp3_addr", mem_addr, 8'h40);
    chk("drp3_state", dbg_state, 2'd1);
    step();
    chk("tgt_valid", inst_valid, 1);
    chk("tgt_pc", inst_pc, 8'h40);
    chk("tgt_palavra", palavra, 16'hC340);
    chk("tgt_addr", mem_addr, 8'h41);

    // Redirect coincident with mem_ack and a pop.
    redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    chk("co_valid", inst_valid, 0);
    chk("co_addr", mem_addr, 8'hFE);
    chk("co_req", mem_req, 1);
    step();
    chk("co1_pc", inst_pc, 8'hFE);
    chk("co1_addr", mem_addr, 8'hFF);
    step();
    chk("wrap_addr", mem_addr, 8'h00);
    chk("wrap_pc", inst_pc, 8'hFF);
    chk("wrap_palavra", palavra, 16'hC3FF);
    step();
    chk("wrap1_addr", mem_addr, 8'h01);
    chk("wrap1_pc", inst_pc, 8'h00);

    // Reset in the middle of an outstanding request.
    mem_ack = 1'b0; stall = 1'b1;
    step();
    chk("pre_rst_req", mem_req, 1);
    chk("pre_rst_addr", mem_addr, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req", mem_req, 0);
    chk("mr_addr", mem_addr, 8'h00);
    chk("mr_valid", inst_valid, 0);
    chk("mr_palavra", palavra, 16'h0000);
    chk("mr_pc", inst_pc, 8'h00);
`ifdef FETCH_COUNT_EN
    chk("mr_count", fetch_count, 16'd0);
`endif
    mem_ack = 1'b1; stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("pr_req", mem_req, 1);
    chk("pr_addr", mem_addr, 8'h00);
    chk("pr_valid", inst_valid, 0);
    step();
    chk("pr1_pc", inst_pc, 8'h00);
    chk("pr1_palavra", palavra, 16'hC300);
`ifdef FETCH_COUNT_EN
    chk("pr1_count", fetch_count, 16'd0);
    step();
    chk("pr2_count", fetch_count, 16'd1);
    step();
    chk("pr3_count", fetch_count, 16'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, meaning instruction-memory word-address width.
REQ-002 SHALL provide parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port mem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL provide port mem_addr  output  ADDR_W  word address of the pending request.
REQ-007 SHALL provide port mem_ack  input  1  request accepted; mem_data valid in the same cycle.
REQ-008 SHALL provide port mem_data  input  16  instruction word returned by memory.
REQ-009 SHALL provide port palavra  output  16  instruction word presented to decode.
REQ-010 SHALL provide port inst_valid  output  1  palavra/inst_pc hold a valid instruction.
REQ-011 SHALL provide port inst_pc  output  ADDR_W  address of palavra.
REQ-012 SHALL provide port stall  input  1  decode not accepting; transfer occurs when inst_valid=1 and stall=0.
REQ-013 SHALL provide ports redirect  input  1  and redirect_pc  input  ADDR_W  branch/jump redirect request and target.

Function
REQ-014 SHALL buffer fetched {pc, instruction} pairs in a 2-entry FIFO; palavra, inst_pc and inst_valid SHALL come from the FIFO head.
REQ-015 SHALL implement FSM states S_IDLE (no request), S_WAIT (mem_req=1, awaiting mem_ack), S_DROP (awaiting mem_ack for a request whose data is discarded).
REQ-016 SHALL hold mem_req=1 and mem_addr stable from issue until the cycle mem_ack=1, with at most one request outstanding.
REQ-017 SHALL move S_IDLE->S_WAIT when FIFO occupancy after this cycle's pop is below 2, driving mem_addr=fetch PC.
REQ-018 SHALL, in S_WAIT with mem_ack=1, push {mem_addr, mem_data}, set fetch PC = mem_addr+1 modulo 2^ADDR_W, and stay in S_WAIT if occupancy after push and pop is below 2, else go to S_IDLE.
REQ-019 SHALL sustain one instruction per cycle when mem_ack is high every cycle and stall=0.
REQ-020 SHALL, on simultaneous push and pop, keep occupancy unchanged and never overflow or underflow the FIFO.
REQ-021 SHALL, on redirect=1, flush the FIFO (inst_valid=0 next cycle), ignore any same-cycle pop, and set fetch PC = redirect_pc.
REQ-022 SHALL, on redirect with a request outstanding and no same-cycle mem_ack, go to S_DROP; on the next mem_ack in S_DROP it SHALL discard mem_data and go to S_WAIT at the redirect target.
REQ-023 SHALL, on redirect coinciding with mem_ack, discard that data and go to S_WAIT with mem_addr=redirect_pc in the next cycle.
REQ-024 SHALL, on redirect with no request outstanding, go to S_WAIT with mem_addr=redirect_pc in the next cycle; a redirect in S_DROP SHALL only update the target.
REQ-025 SHALL keep palavra and inst_pc stable while inst_valid=1 and stall=1.

Reset
REQ-026 SHALL, while rst_n=0, force state=S_IDLE, mem_req=0, mem_addr=RESET_PC, fetch PC=RESET_PC, FIFO empty, inst_valid=0, palavra=0, inst_pc=0.
REQ-027 SHALL issue the first request (mem_req=1, mem_addr=RESET_PC) on the first rising edge after rst_n deasserts.
REQ-028 SHALL, on reset mid-request, abandon the outstanding request immediately; a later mem_ack SHALL be ignored.

Configuration
REQ-029 SHALL, with macro FETCH_COUNT_EN defined, add output fetch_count (16 bits, reset 0) incrementing by 1, wrapping at 65535->0, on every decode transfer.
REQ-030 SHALL, without FETCH_COUNT_EN, have no fetch_count port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-031 SHALL cover: release reset, mem_ack=1 every cycle, stall=0 -> mem_addr 0,1,2,3 on consecutive cycles; inst_pc 0,1,2 one cycle behind each ack.
REQ-032 SHALL cover: stall=1 held 5 cycles with memory always acking -> exactly 2 words buffered, mem_req=0, palavra unchanged; stall=0 -> both drain in order.
REQ-033 SHALL cover: redirect=1, redirect_pc=8'h40 while request to 8'h05 is outstanding and acked 3 cycles later -> 8'h05 data never appears; next request mem_addr=8'h40.
REQ-034 SHALL cover: redirect coincident with mem_ack and pop -> no valid output next cycle; mem_addr=redirect_pc next cycle.
REQ-035 SHALL cover: fetch PC 8'hFF acked -> next mem_addr=8'h00.
REQ-036 SHALL cover: rst_n pulsed low mid-request -> outputs at reset values immediately; first post-reset request at RESET_PC; with FETCH_COUNT_EN, fetch_count=0 then counts each transfer.
